// File: rtl/if_fetch_buffer_if.sv
// Fetch-stage bus bundle: branch redirect inputs, instruction ROM port and
// the valid/ready instruction stream towards decode.
interface if_fetch_buffer_if #(
    parameter int PC_WIDTH     = 8,
    parameter int INSTR_WIDTH  = 16,
    parameter int OFFSET_WIDTH = 6
);
    logic                    fetch_en;
    logic                    branch_taken;
    logic [PC_WIDTH-1:0]     branch_pc;
    logic [OFFSET_WIDTH-1:0] branch_offset;
    logic                    imem_req;
    logic [PC_WIDTH-1:0]     imem_addr;
    logic [INSTR_WIDTH-1:0]  imem_rdata;
    logic                    instr_valid;
    logic                    instr_ready;
    logic [INSTR_WIDTH-1:0]  instr;
    logic [PC_WIDTH-1:0]     instr_pc;

    modport master (
        input  fetch_en, branch_taken, branch_pc, branch_offset, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output fetch_en, branch_taken, branch_pc, branch_offset, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// Instruction fetch stage: PC generator, one-deep in-flight tracker for a
// 1-cycle ROM, and a prefetch FIFO of {instr, pc} feeding decode.
module if_fetch_buffer #(
    parameter int                  PC_WIDTH     = 8,
    parameter int                  INSTR_WIDTH  = 16,
    parameter int                  OFFSET_WIDTH = 6,
    parameter int                  FIFO_DEPTH   = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = {PC_WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_buffer_if.master  bus
);
    localparam int                 PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                 CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    logic [PC_WIDTH-1:0]    fetch_pc_r;
    logic                   inflight_r;
    logic [PC_WIDTH-1:0]    inflight_pc_r;
    logic [INSTR_WIDTH-1:0] fifo_instr_r [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]    fifo_pc_r    [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;

    logic [PC_WIDTH-1:0]    offset_ext_s;
    logic [PC_WIDTH-1:0]    target_s;
    logic [CNT_W-1:0]       occupancy_s;
    logic                   req_s;
    logic                   push_s;
    logic                   pop_s;

    // Request/push/pop decisions and branch target; a redirect suppresses all three.
    always_comb begin
        offset_ext_s = PC_WIDTH'($signed(bus.branch_offset));
        target_s     = bus.branch_pc + offset_ext_s;
        // In-flight data already owns a FIFO slot, so it counts towards occupancy.
        occupancy_s  = count_r + {{(CNT_W-1){1'b0}}, inflight_r};
        req_s        = 1'b0;
        if (!rst && bus.fetch_en && !bus.branch_taken && (occupancy_s < DEPTH_C)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        push_s = inflight_r & ~bus.branch_taken;
        pop_s  = (count_r != {CNT_W{1'b0}}) & bus.instr_ready & ~bus.branch_taken;
    end

    // Fetch PC, in-flight tracker, FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= RESET_PC;
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else if (bus.branch_taken) begin
            fetch_pc_r <= target_s;
            inflight_r <= 1'b0;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            inflight_r <= req_s;
            if (req_s) begin
                fetch_pc_r    <= fetch_pc_r + PC_ONE;
                inflight_pc_r <= fetch_pc_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_instr_r[wr_ptr_r] <= bus.imem_rdata;
            fifo_pc_r[wr_ptr_r]    <= inflight_pc_r;
        end
    end

    assign bus.imem_req    = req_s;
    assign bus.imem_addr   = fetch_pc_r;
    assign bus.instr_valid = (count_r != {CNT_W{1'b0}});
    assign bus.instr       = fifo_instr_r[rd_ptr_r];
    assign bus.instr_pc    = fifo_pc_r[rd_ptr_r];
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Self-checking bench for if_fetch_buffer: directed scenarios plus a randomized
// run against a queue-based reference model of the fetch stage.
module tb_if_fetch_buffer;
    localparam int PW = 8, IW = 16, OW = 6, DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    if_fetch_buffer_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .OFFSET_WIDTH(OW)) bus ();

    if_fetch_buffer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .OFFSET_WIDTH(OW),
                      .FIFO_DEPTH(DEPTH), .RESET_PC(8'h00))
        dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [15:0] rom(input logic [7:0] a);
        return 16'h1000 + {8'h00, a};
    endfunction

    // Synchronous ROM: data for a request appears the following cycle, garbage otherwise.
    always @(posedge clk) begin
        if (bus.imem_req === 1'b1) bus.imem_rdata <= rom(bus.imem_addr);
        else                       bus.imem_rdata <= 16'hDEAD;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic fe, input logic rdy);
        rst = 1'b1;
        bus.fetch_en = fe; bus.instr_ready = rdy; bus.branch_taken = 1'b0;
        bus.branch_pc = 8'h00; bus.branch_offset = 6'h00;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.fetch_en = 1'b1; bus.instr_ready = 1'b1;
        cyc(); cyc(); #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", bus.imem_addr); end
    endtask

    task automatic test_stream();
        reset_dut(1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'(k)) begin
                errors++; $display("FAIL stream_req cyc%0d got req=%b addr=%h exp req=1 addr=%h", k + 1, bus.imem_req, bus.imem_addr, 8'(k));
            end
            checks++;
            if (k >= 2) begin
                if (bus.instr_valid !== 1'b1 || bus.instr !== rom(8'(k - 2)) || bus.instr_pc !== 8'(k - 2)) begin
                    errors++; $display("FAIL stream_data cyc%0d got v=%b i=%h pc=%h exp v=1 i=%h pc=%h", k + 1, bus.instr_valid, bus.instr, bus.instr_pc, rom(8'(k - 2)), 8'(k - 2));
                end
            end else if (bus.instr_valid !== 1'b0) begin
                errors++; $display("FAIL stream_early_valid cyc%0d got %b exp 0", k + 1, bus.instr_valid);
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        reset_dut(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bus.imem_req === 1'b1) begin
                checks++;
                if (bus.imem_addr !== 8'(nreq)) begin errors++; $display("FAIL bp_addr got %h exp %h", bus.imem_addr, 8'(nreq)); end
                nreq++;
            end
            cyc();
        end
        checks++; if (nreq != DEPTH) begin errors++; $display("FAIL bp_count got %0d exp %0d", nreq, DEPTH); end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i == 0) begin
                checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req got %b exp 0", bus.imem_req); end
            end else if (i == 1) begin
                checks++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h04) begin
                    errors++; $display("FAIL bp_resume got req=%b addr=%h exp req=1 addr=04", bus.imem_req, bus.imem_addr);
                end
            end
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== rom(8'(i)) || bus.instr_pc !== 8'(i)) begin
                errors++; $display("FAIL bp_drain %0d got v=%b i=%h pc=%h exp i=%h", i, bus.instr_valid, bus.instr, bus.instr_pc, rom(8'(i)));
            end
            cyc();
        end
    endtask

    // Branch while the FIFO pushes (in-flight 5) and pops (head 4) in the same cycle.
    task automatic test_branch();
        reset_dut(1'b1, 1'b1);
        repeat (6) cyc();
        bus.branch_taken = 1'b1; bus.branch_pc = 8'h05; bus.branch_offset = 6'b111110;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL br_req_in_b got %b exp 0", bus.imem_req); end
        cyc();
        bus.branch_taken = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL br_flush got v=%b exp 0", bus.instr_valid); end
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h03) begin
            errors++; $display("FAIL br_target_req got req=%b addr=%h exp req=1 addr=03", bus.imem_req, bus.imem_addr);
        end
        cyc(); #1;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL br_stale got v=%b pc=%h exp v=0", bus.instr_valid, bus.instr_pc); end
        cyc();
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(3 + j) || bus.instr !== rom(8'(3 + j))) begin
                errors++; $display("FAIL br_seq %0d got v=%b i=%h pc=%h exp pc=%h", j, bus.instr_valid, bus.instr, bus.instr_pc, 8'(3 + j));
            end
            cyc();
        end
    endtask

    // Branch with a full FIFO and a pop requested in the branch cycle.
    task automatic test_branch_full();
        reset_dut(1'b1, 1'b0);
        repeat (8) cyc();
        bus.branch_taken = 1'b1; bus.branch_pc = 8'h40; bus.branch_offset = 6'd10; bus.instr_ready = 1'b1;
        cyc();
        bus.branch_taken = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'h4A) begin
            errors++; $display("FAIL brf_flush got v=%b addr=%h exp v=0 addr=4a", bus.instr_valid, bus.imem_addr);
        end
        cyc(); cyc();
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(8'h4A + j)) begin
                errors++; $display("FAIL brf_seq %0d got v=%b pc=%h exp %h", j, bus.instr_valid, bus.instr_pc, 8'(8'h4A + j));
            end
            cyc();
        end
    endtask

    task automatic test_wrap();
        reset_dut(1'b1, 1'b1);
        bus.branch_taken = 1'b1; bus.branch_pc = 8'hFC; bus.branch_offset = 6'd2;
        cyc();
        bus.branch_taken = 1'b0;
        for (int j = 0; j < 6; j++) begin
            #1;
            if (j < 3) begin
                checks++;
                if (bus.imem_addr !== 8'(8'hFE + j)) begin errors++; $display("FAIL wrap_addr %0d got %h exp %h", j, bus.imem_addr, 8'(8'hFE + j)); end
            end
            if (j >= 2) begin
                checks++;
                if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(8'hFE + j - 2)) begin
                    errors++; $display("FAIL wrap_pc %0d got v=%b pc=%h exp %h", j, bus.instr_valid, bus.instr_pc, 8'(8'hFE + j - 2));
                end
            end
            cyc();
        end
        bus.branch_taken = 1'b1; bus.branch_pc = 8'hFF; bus.branch_offset = 6'd3;
        cyc();
        bus.branch_taken = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 8'h02) begin errors++; $display("FAIL wrap_target got %h exp 02", bus.imem_addr); end
        cyc(); cyc(); #1;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h02 || bus.instr !== 16'h1002) begin
            errors++; $display("FAIL wrap_target_instr got v=%b i=%h pc=%h exp i=1002 pc=02", bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

    task automatic test_fetch_en_drop();
        reset_dut(1'b1, 1'b1);
        cyc();
        bus.fetch_en = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            #1;
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL fe_req cyc%0d got %b exp 0", c, bus.imem_req); end
            checks++;
            if (c == 3) begin
                if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h1000 || bus.instr_pc !== 8'h00) begin
                    errors++; $display("FAIL fe_deliver got v=%b i=%h pc=%h exp i=1000 pc=00", bus.instr_valid, bus.instr, bus.instr_pc);
                end
            end else if (bus.instr_valid !== 1'b0) begin
                errors++; $display("FAIL fe_valid cyc%0d got %b exp 0", c, bus.instr_valid);
            end
            cyc();
        end
        bus.fetch_en = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) begin
            errors++; $display("FAIL fe_resume got req=%b addr=%h exp req=1 addr=01", bus.imem_req, bus.imem_addr);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        reset_dut(1'b1, 1'b1);
        repeat (5) cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h00) begin
            errors++; $display("FAIL rmid_clear got v=%b req=%b addr=%h exp 0 0 00", bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
        cyc(); cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
            errors++; $display("FAIL rmid_restart got req=%b addr=%h exp req=1 addr=00", bus.imem_req, bus.imem_addr);
        end
        cyc(); cyc(); #1;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00 || bus.instr !== 16'h1000) begin
            errors++; $display("FAIL rmid_first got v=%b i=%h pc=%h exp i=1000 pc=00", bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

    // Reference model: a queue of delivered {instr, pc}, a pending ROM slot and a PC.
    task automatic test_random();
        logic [23:0] q[$];
        logic [7:0]  m_pc = 8'h00;
        logic [7:0]  ipc  = 8'h00;
        bit          infl = 1'b0;
        bit          fe, rdy, br, exp_req;
        logic [7:0]  bpc;
        logic [5:0]  off;
        int          o;
        reset_dut(1'b1, 1'b1);
        for (int n = 0; n < 600; n++) begin
            fe  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            br  = ($urandom_range(0, 11) == 0);
            bpc = 8'($urandom);
            off = 6'($urandom);
            bus.fetch_en = fe; bus.instr_ready = rdy; bus.branch_taken = br;
            bus.branch_pc = bpc; bus.branch_offset = off;
            #1;
            exp_req = fe && !br && ((q.size() + int'(infl)) < DEPTH);
            checks++;
            if (bus.imem_req !== exp_req || bus.imem_addr !== m_pc) begin
                errors++; $display("FAIL rnd_req n=%0d got req=%b addr=%h exp req=%b addr=%h", n, bus.imem_req, bus.imem_addr, exp_req, m_pc);
            end
            checks++;
            if (bus.instr_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, bus.instr_valid, q.size() != 0);
            end else if (q.size() != 0 && {bus.instr, bus.instr_pc} !== q[0]) begin
                errors++; $display("FAIL rnd_head n=%0d got %h exp %h", n, {bus.instr, bus.instr_pc}, q[0]);
            end
            if (br) begin
                o = int'(off);
                if (off[5]) o = o - 64;
                m_pc = 8'((int'(bpc) + o + 256) % 256);
                q.delete();
                infl = 1'b0;
            end else begin
                if (q.size() != 0 && rdy) void'(q.pop_front());
                if (infl) q.push_back({rom(ipc), ipc});
                if (exp_req) begin
                    ipc  = m_pc;
                    m_pc = m_pc + 8'd1;
                end
                infl = exp_req;
            end
            cyc();
        end
        bus.branch_taken = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.fetch_en = 1'b0; bus.instr_ready = 1'b0; bus.branch_taken = 1'b0;
        bus.branch_pc = 8'h00; bus.branch_offset = 6'h00;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_branch_full();
        test_wrap();
        test_fetch_en_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
